// File: rtl/offset14_dac_pacer_pkg.sv
// Shared constants and state encoding for the offset-binary DAC pacer.
package offset14_dac_pacer_pkg;

  localparam int          DATA_W_DEF   = 14;
  localparam logic [13:0] OFFSET14_MID = 14'h2000;

  // 2'd3 is unreachable and is decoded as IDLE by the pacer FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } pacer_state_t;

endpackage

// File: rtl/offset14_dac_pacer_sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers; read data is the current head.
module offset14_dac_pacer_sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 14
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_ff @(posedge aclk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/offset14_dac_pacer.sv
// Paces buffered offset-binary samples out to a parallel DAC at a programmable period.
//
//   state | meaning
//   IDLE  | disabled, DAC parked at midscale, no ticks
//   PRIME | enabled, waiting for the FIFO to reach half full
//   RUN   | period counter running, one DAC write per tick
module offset14_dac_pacer
  import offset14_dac_pacer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = 16
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
  input  logic                   clr_underflow,
  output logic [DATA_W-1:0]      dac_data,
  output logic                   dac_wr,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]     HALF = LW'(DEPTH / 2);
  localparam logic [DATA_W-1:0] MID  = (DATA_W == DATA_W_DEF) ? DATA_W'(OFFSET14_MID)
                                                              : (DATA_W'(1) << (DATA_W - 1));

  pacer_state_t      state;
  pacer_state_t      state_next;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  cnt_next;
  logic [DIV_W-1:0]  load_val;
  logic              tick;
  logic              park;

  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [DATA_W-1:0] head;

  assign s_ready  = ~full;
  assign push     = s_valid & s_ready;
  assign pop      = tick & ~empty;
  // div of 0 and 1 both mean a tick every cycle.
  assign load_val = (div <= DIV_W'(1)) ? '0 : div - DIV_W'(1);

  offset14_dac_pacer_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sample_fifo (
    .aclk    (aclk),
    .rst     (rst),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge aclk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tick       = 1'b0;
    park       = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (enable) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable) begin
          state_next = ST_IDLE;
          park       = 1'b1;
        end else if (level >= HALF) begin
          state_next = ST_RUN;
          cnt_next   = load_val;
        end
      end
      ST_RUN: begin
        // Disable takes precedence over a coincident tick so the park word wins.
        if (!enable) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          park       = 1'b1;
        end else if (cnt == '0) begin
          tick     = 1'b1;
          cnt_next = load_val;
        end else begin
          cnt_next = cnt - DIV_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!rst) begin
      dac_data  <= MID;
      dac_wr    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      dac_wr <= tick | park;
      if (park)     dac_data <= MID;
      else if (pop) dac_data <= head;
      // An empty tick re-latches the held word and takes priority over a clear.
      if (tick && empty)  underflow <= 1'b1;
      else if (clr_underflow) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_offset14_dac_pacer.sv
// Directed bench for offset14_dac_pacer: reset, full, priming/pacing, div change, park, underflow.
module tb_offset14_dac_pacer;

  logic        aclk = 1'b0;
  logic        rst;
  logic [13:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        enable;
  logic [15:0] div;
  logic        clr_underflow;
  logic [13:0] dac_data;
  logic        dac_wr;
  logic        underflow;
  logic [4:0]  level;

  int          vectors = 0;
  int          errors  = 0;
  logic [13:0] q[$];

  always #5 aclk = ~aclk;

  offset14_dac_pacer dut (
    .aclk          (aclk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .enable        (enable),
    .div           (div),
    .clr_underflow (clr_underflow),
    .dac_data      (dac_data),
    .dac_wr        (dac_wr),
    .underflow     (underflow),
    .level         (level)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [13:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    q.push_back(d);
  endtask

  // Steps until a DAC strobe is seen or the budget runs out; n is cycles waited.
  task automatic wait_wr(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dac_wr && n < budget);
  endtask

  initial begin
    int          n;
    int          strobes;
    logic [13:0] exp_d;
    logic [13:0] last_d;

    rst = 1'b0; s_valid = 1'b1; s_data = 14'h1234; enable = 1'b0;
    div = 16'd4; clr_underflow = 1'b0;

    // Reset held three cycles with s_valid asserted
    repeat (3) step();
    chk("rst_dac_data", dac_data, 14'h2000);
    chk("rst_dac_wr", dac_wr, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_underflow", underflow, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_level_after", level, 5'd0);

    // Fill to full while disabled; the 17th sample must be refused
    for (int k = 1; k <= 17; k++) begin
      s_valid = 1'b1;
      s_data  = 14'(k);
      step();
      chk($sformatf("full_s_ready_%0d", k), s_ready, (k < 16) ? 1'b1 : 1'b0);
    end
    s_valid = 1'b0;
    chk("full_level", level, 5'd16);
    chk("full_no_wr", dac_wr, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("clear_level", level, 5'd0);

    // Priming and pacing at div=4
    enable = 1'b1;
    div    = 16'd4;
    strobes = 0;
    foreach (q[i]) q.delete(i);
    push(14'h36C8); strobes += dac_wr;
    push(14'h3C00); strobes += dac_wr;
    push(14'h3C2F); strobes += dac_wr;
    push(14'h2BA1); strobes += dac_wr;
    push(14'h1D5F); strobes += dac_wr;
    push(14'h03D1); strobes += dac_wr;
    push(14'h0000); strobes += dac_wr;
    push(14'h3FFF); strobes += dac_wr;
    chk("prime_no_wr", strobes, 0);
    chk("prime_level", level, 5'd8);

    wait_wr(20, n);
    exp_d = q.pop_front();
    chk("pace_first_wr", dac_wr, 1'b1);
    chk("pace_first_lat", n, 5);
    chk("pace_first_data", dac_data, exp_d);
    chk("pace_level_7", level, 5'd7);
    for (int i = 0; i < 2; i++) begin
      wait_wr(20, n);
      exp_d = q.pop_front();
      chk("pace_wr", dac_wr, 1'b1);
      chk("pace_period_4", n, 4);
      chk("pace_data", dac_data, exp_d);
    end

    // Counter already loaded for this period; new div applies at the next reload
    div = 16'd7;
    wait_wr(20, n);
    exp_d = q.pop_front();
    chk("divchg_old_period", n, 4);
    chk("divchg_data_a", dac_data, exp_d);
    wait_wr(20, n);
    exp_d = q.pop_front();
    chk("divchg_new_period", n, 7);
    chk("divchg_data_b", dac_data, exp_d);
    chk("divchg_level", level, 5'd3);

    // Disable parks at midscale with exactly one strobe
    enable = 1'b0;
    step();
    chk("park_wr", dac_wr, 1'b1);
    chk("park_data", dac_data, 14'h2000);
    strobes = 0;
    repeat (8) begin
      step();
      strobes += dac_wr;
    end
    chk("park_quiet", strobes, 0);
    chk("park_level_kept", level, 5'd3);

    // Underflow: eight samples at div=2, then empty ticks
    push(14'h0ABC);
    push(14'h1111);
    push(14'h2222);
    push(14'h3333);
    push(14'h0001);
    chk("uf_level", level, 5'd8);
    div    = 16'd2;
    enable = 1'b1;
    last_d = 14'h0;
    for (int i = 0; i < 8; i++) begin
      wait_wr(20, n);
      exp_d = q.pop_front();
      chk("uf_wr", dac_wr, 1'b1);
      chk("uf_data", dac_data, exp_d);
      chk("uf_period", n, (i == 0) ? 4 : 2);
      last_d = exp_d;
    end
    chk("uf_not_yet", underflow, 1'b0);
    wait_wr(20, n);
    chk("uf_empty_wr", dac_wr, 1'b1);
    chk("uf_empty_period", n, 2);
    chk("uf_data_held", dac_data, last_d);
    chk("uf_set", underflow, 1'b1);
    step();
    clr_underflow = 1'b1;
    step();
    chk("uf_clr_tick_wr", dac_wr, 1'b1);
    chk("uf_set_wins", underflow, 1'b1);
    step();
    chk("uf_cleared", underflow, 1'b0);
    clr_underflow = 1'b0;
    div = 16'd200;
    step();
    chk("uf_tick_reload", dac_wr, 1'b1);

    // Reset mid-RUN with five samples queued
    push(14'h0100);
    push(14'h0200);
    push(14'h0300);
    push(14'h0400);
    push(14'h0500);
    chk("midrst_level_pre", level, 5'd5);
    rst = 1'b0;
    step();
    chk("midrst_level", level, 5'd0);
    chk("midrst_data", dac_data, 14'h2000);
    chk("midrst_wr", dac_wr, 1'b0);
    chk("midrst_underflow", underflow, 1'b0);
    rst = 1'b1;
    strobes = 0;
    repeat (4) begin
      step();
      strobes += dac_wr;
    end
    chk("midrst_idle_quiet", strobes, 0);
    chk("midrst_s_ready", s_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
